// File: rtl/led_frame_arbiter.sv
// ============================================================================
// Module   : led_frame_arbiter
// Purpose  : Round-robin arbiter that shares one WS2812B frame transmitter
//            between NREQ pattern sources, with latch-gap and watchdog timing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_frame_arbiter #(
    parameter int NREQ    = 3,
    parameter int FRAME_W = 96,
    parameter int MIN_GAP = 6000,
    parameter int TIMEOUT = 20000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*FRAME_W-1:0]   frameIn,
    input  logic                      clrErr,
    input  logic                      txDone,
    output logic [NREQ-1:0]           grant,
    output logic                      txGo,
    output logic [FRAME_W-1:0]        txFrame,
    output logic                      busy,
    output logic                      timeoutErr
);

    localparam int PTR_W   = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int MAX_CNT = (MIN_GAP > TIMEOUT) ? MIN_GAP : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_GO   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_q;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] frame_q;
    logic               err_q;

    logic               req_hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tmo_hit;
    logic               gap_end;
    logic               wait_exit;
    logic [PTR_W-1:0]   rr_next;
    logic [FRAME_W-1:0] frames [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_frames
        assign frames[g] = frameIn[g*FRAME_W +: FRAME_W];
    end

    // First requester found scanning upward from the round-robin pointer.
    always_comb begin
        int idx;
        req_hit = 1'b0;
        win_d   = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx[PTR_W-1:0]]) begin
                req_hit = 1'b1;
                win_d   = idx[PTR_W-1:0];
            end
        end
    end

    // Timeout fires when the incremented count reaches TIMEOUT-1, i.e. TIMEOUT
    // cycles after the txGo cycle.
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign tmo_hit   = (state_q == S_WAIT) && (cnt_inc == CNT_W'(TIMEOUT - 1));
    assign gap_end   = (cnt_q == CNT_W'(MIN_GAP - 1));
    assign wait_exit = (state_q == S_WAIT) && (txDone || tmo_hit);
    assign rr_next   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_hit) state_d = S_LOAD;
            S_LOAD:  state_d = S_GO;
            S_GO:    state_d = S_WAIT;
            S_WAIT:  if (txDone || tmo_hit) state_d = S_GAP;
            S_GAP:   if (gap_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant      = '0;
        txGo       = (state_q == S_GO);
        busy       = (state_q != S_IDLE);
        txFrame    = frame_q;
        timeoutErr = err_q;
        if (state_q == S_LOAD) begin
            grant = NREQ'(1) << win_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q    <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && req_hit) begin
                win_q   <= win_d;
                frame_q <= frames[win_d];
            end

            if (state_q == S_GO) begin
                cnt_q <= '0;
            end else if (wait_exit) begin
                cnt_q <= '0;
                rr_q  <= rr_next;
            end else if ((state_q == S_WAIT) || (state_q == S_GAP)) begin
                cnt_q <= cnt_inc;
            end

            // A done in the same cycle as the timeout wins, so no error then.
            if (tmo_hit && !txDone) begin
                err_q <= 1'b1;
            end else if (clrErr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_frame_arbiter.sv
// ============================================================================
// Module   : tb_led_frame_arbiter
// Purpose  : Self-checking bench for led_frame_arbiter against a
//            transaction-level round-robin / timing model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_frame_arbiter;

    localparam int NREQ    = 3;
    localparam int FRAME_W = 96;
    localparam int MIN_GAP = 8;
    localparam int TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ*FRAME_W-1:0] frameIn;
    logic                    clrErr;
    logic                    txDone;
    logic [NREQ-1:0]         grant;
    logic                    txGo;
    logic [FRAME_W-1:0]      txFrame;
    logic                    busy;
    logic                    timeoutErr;

    logic [FRAME_W-1:0] fr [NREQ];
    int checks   = 0;
    int failures = 0;
    int m_rr     = 0;
    logic m_err  = 1'b0;
    int n_grant  = 0;
    int n_go     = 0;

    led_frame_arbiter #(
        .NREQ    (NREQ),
        .FRAME_W (FRAME_W),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .frameIn    (frameIn),
        .clrErr     (clrErr),
        .txDone     (txDone),
        .grant      (grant),
        .txGo       (txGo),
        .txFrame    (txFrame),
        .busy       (busy),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|grant) n_grant++;
        if (txGo)   n_go++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic new_frames();
        for (int i = 0; i < NREQ; i++) begin
            fr[i] = {$urandom, $urandom, $urandom};
        end
        frameIn = {fr[2], fr[1], fr[0]};
    endtask

    // Round-robin reference: first set request at or after the pointer.
    function automatic int pick(input int rr, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // d > 0: txDone sampled d edges after the txGo edge; d == 0: never done.
    task automatic run_frame(input logic [NREQ-1:0] r, input int d, input bit hold,
                             input bit clr_set, input bit gap_req);
        int w;
        logic [FRAME_W-1:0] exp_frame;
        new_frames();
        req = r;
        w = pick(m_rr, r);
        step();
        chk("grant", {93'd0, grant}, 96'(3'b001 << w));
        chk("txGo_load", {95'd0, txGo}, 96'd0);
        chk("busy_load", {95'd0, busy}, 96'd1);
        chk("txFrame", txFrame, fr[w]);
        exp_frame = fr[w];
        if (!hold) req = r & ~(3'b001 << w);
        step();
        chk("txGo_go", {95'd0, txGo}, 96'd1);
        chk("grant_go", {93'd0, grant}, 96'd0);
        new_frames();
        if (d > 0) begin
            repeat (d - 1) begin
                step();
                chk("txGo_wait", {95'd0, txGo}, 96'd0);
            end
            txDone = 1'b1;
            step();
            txDone = 1'b0;
        end else begin
            repeat (TIMEOUT - 1) begin
                step();
                chk("err_before_tmo", {95'd0, timeoutErr}, 96'(m_err));
            end
            if (clr_set) clrErr = 1'b1;
            step();
            clrErr = 1'b0;
            m_err  = 1'b1;
        end
        chk("timeoutErr_exit", {95'd0, timeoutErr}, 96'(m_err));
        m_rr = (w + 1) % NREQ;
        if (gap_req) req = 3'b001;
        chk("busy_gap0", {95'd0, busy}, 96'd1);
        for (int g = 1; g < MIN_GAP; g++) begin
            step();
            chk("busy_gap", {95'd0, busy}, 96'd1);
            chk("grant_gap", {93'd0, grant}, 96'd0);
        end
        if (gap_req) req = 3'b000;
        step();
        chk("busy_idle", {95'd0, busy}, 96'd0);
        chk("txFrame_hold", txFrame, exp_frame);
    endtask

    initial begin
        int g0;
        int go0;
        reset   = 1'b0;
        req     = '0;
        clrErr  = 1'b0;
        txDone  = 1'b0;
        frameIn = '0;

        // Reset held with random inputs
        repeat (4) begin
            req     = NREQ'($urandom);
            txDone  = 1'($urandom);
            clrErr  = 1'($urandom);
            new_frames();
            step();
            chk("rst_grant", {93'd0, grant}, 96'd0);
            chk("rst_txGo", {95'd0, txGo}, 96'd0);
            chk("rst_txFrame", txFrame, 96'd0);
            chk("rst_busy", {95'd0, busy}, 96'd0);
            chk("rst_err", {95'd0, timeoutErr}, 96'd0);
        end
        req = '0; txDone = 1'b0; clrErr = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("idle_busy", {95'd0, busy}, 96'd0);
            chk("idle_grant", {93'd0, grant}, 96'd0);
        end

        // Round robin with all requests held
        g0 = n_grant; go0 = n_go;
        for (int i = 0; i < 4; i++) begin
            run_frame(3'b111, int'($urandom_range(2, TIMEOUT)), 1'b1, 1'b0, 1'b0);
        end
        chk("rr_grant_count", 96'(n_grant - g0), 96'd4);
        chk("rr_go_count", 96'(n_go - go0), 96'(n_grant - g0));
        req = '0;

        // Single request, done 20 cycles after txGo
        run_frame(3'b010, 20, 1'b0, 1'b0, 1'b0);

        // Done coincident with timeout counts as done
        run_frame(3'b100, TIMEOUT, 1'b0, 1'b0, 1'b0);

        // Timeout, then clear; then timeout with clear on the set cycle
        run_frame(3'b001, 0, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", {95'd0, timeoutErr}, 96'd1);
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        m_err  = 1'b0;
        chk("err_cleared", {95'd0, timeoutErr}, 96'd0);
        run_frame(3'b001, 0, 1'b0, 1'b1, 1'b0);
        chk("err_set_wins", {95'd0, timeoutErr}, 96'd1);
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        m_err  = 1'b0;
        chk("err_cleared2", {95'd0, timeoutErr}, 96'd0);

        // Asynchronous reset in the middle of WAIT
        req = 3'b010;
        step();
        step();
        req = '0;
        repeat (5) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_txGo", {95'd0, txGo}, 96'd0);
        chk("arst_busy", {95'd0, busy}, 96'd0);
        chk("arst_grant", {93'd0, grant}, 96'd0);
        chk("arst_txFrame", txFrame, 96'd0);
        step();
        reset = 1'b1;
        m_rr  = 0;
        m_err = 1'b0;
        run_frame(3'b100, int'($urandom_range(2, TIMEOUT)), 1'b0, 1'b0, 1'b0);

        // Request only during GAP, withdrawn before IDLE
        run_frame(3'b010, 5, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            step();
            chk("withdraw_grant", {93'd0, grant}, 96'd0);
            chk("withdraw_busy", {95'd0, busy}, 96'd0);
        end

        // Stray done in IDLE
        txDone = 1'b1;
        step();
        txDone = 1'b0;
        chk("stray_busy", {95'd0, busy}, 96'd0);
        step();
        chk("stray_busy2", {95'd0, busy}, 96'd0);
        chk("stray_txGo", {95'd0, txGo}, 96'd0);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            run_frame(NREQ'($urandom_range(1, 7)), int'($urandom_range(2, TIMEOUT)),
                      1'($urandom), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
